// File: rtl/simple_mem_responder_if.sv
// CPU data-memory port bundle shared by the CPU (master) and the memory responder (slave).
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and holds it until it sees
// mem_ready. The slave pulses mem_ready for exactly one cycle per completed transaction.
// mem_rdata and mem_err are valid only in that cycle. Dropping mem_req before mem_ready aborts.
interface simple_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/simple_mem_responder.sv
// Word-array memory behind the CPU mem_req/mem_ready port: configurable wait states,
// out-of-range flagging, registered outputs; FSM state is exported on state_o.
module simple_mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  simple_mem_responder_if.slave  bus,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cap_en;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;

  logic [DATA_W-1:0] mem_q [2**IDX_W];

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return 32'(a) >= DEPTH;
  endfunction

  // State register plus the request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_en) begin
        we_q    <= bus.mem_we;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          cap_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mem_req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, before the capture lands.
  always_comb begin
    sel_we   = (state_q == S_IDLE) ? bus.mem_we   : we_q;
    sel_addr = (state_q == S_IDLE) ? bus.mem_addr : addr_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (state_d == S_RESP) begin
      ready_d = 1'b1;
      err_d   = out_of_range(sel_addr);
      if (!sel_we) begin
        rdata_d = out_of_range(sel_addr) ? '0 : mem_q[sel_addr[IDX_W-1:0]];
      end
    end
  end

  // The write commits at the edge that ends RESP, so a reset in RESP discards it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && we_q && !out_of_range(addr_q)) begin
      mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_err   = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_simple_mem_responder.sv
// Directed bench for simple_mem_responder: one instance with 2 wait states / 256 words and one
// with 0 wait states / 16 words, sharing a request bus gated by sel.
module tb_simple_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       req = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       ready, err;
  logic [7:0] rdata;
  logic [1:0] st_a, st_b, st;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simple_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if_a ();
  simple_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if_b ();

  assign if_a.mem_req   = req & ~sel;
  assign if_a.mem_we    = we;
  assign if_a.mem_addr  = addr;
  assign if_a.mem_wdata = wdata;
  assign if_b.mem_req   = req & sel;
  assign if_b.mem_we    = we;
  assign if_b.mem_addr  = addr;
  assign if_b.mem_wdata = wdata;

  assign ready = sel ? if_b.mem_ready : if_a.mem_ready;
  assign rdata = sel ? if_b.mem_rdata : if_a.mem_rdata;
  assign err   = sel ? if_b.mem_err   : if_a.mem_err;
  assign st    = sel ? st_b : st_a;

  simple_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_a.slave),
    .state_o (st_a)
  );

  simple_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_b.slave),
    .state_o (st_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ready) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Request issued in the current cycle; lat is the number of cycles until mem_ready (-1 on timeout).
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input string tag,
                         output int lat, output logic [7:0] rd, output logic er);
    int start;
    start = cyc;
    we = w; addr = a; wdata = d; req = 1'b1;
    lat = -1; rd = 8'h00; er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ready) begin
        lat = cyc - start;
        rd  = rdata;
        er  = err;
        break;
      end
    end
    req = 1'b0;
    tick();
    chk({tag, "_rdy_low"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int lat, p1, p2;
    logic [7:0] rd;
    logic er, seen;

    // Reset held with a pending request.
    req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 8'hA5;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen = seen | ready | err | (|rdata);
    end
    chk("rst_outputs", 32'(seen), 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    rst = 1'b0; req = 1'b0;

    // WAIT_CYCLES=2 instance.
    run_txn(1'b1, 8'h10, 8'hA5, "wr10", lat, rd, er);
    chk("wr10_lat", 32'(lat), 32'd3);
    chk("wr10_err", 32'(er), 32'd0);
    run_txn(1'b0, 8'h10, 8'h00, "rd10", lat, rd, er);
    chk("rd10_lat", 32'(lat), 32'd3);
    chk("rd10_data", 32'(rd), 32'hA5);

    we = 1'b1; addr = 8'h01; wdata = 8'h3C; req = 1'b1;
    wait_ready(p1);
    we = 1'b0;
    wait_ready(p2);
    rd = rdata;
    req = 1'b0;
    tick();
    chk("b2b_gap", 32'(p2 - p1), 32'd4);
    chk("b2b_data", 32'(rd), 32'h3C);
    chk("b2b_p1_seen", 32'(p1 >= 0), 32'd1);

    run_txn(1'b1, 8'h05, 8'h11, "wr05", lat, rd, er);
    chk("wr05_lat", 32'(lat), 32'd3);

    // Abort in the first WAIT cycle.
    we = 1'b1; addr = 8'h05; wdata = 8'hFF; req = 1'b1;
    tick();
    req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | ready;
    end
    chk("abort_no_rdy", 32'(seen), 32'd0);
    chk("abort_state", 32'(st), 32'd0);
    run_txn(1'b0, 8'h05, 8'h00, "abort_rd", lat, rd, er);
    chk("abort_rd_data", 32'(rd), 32'h11);

    // Reset in WAIT: rdata currently holds 0x11 and must clear.
    we = 1'b1; addr = 8'h05; wdata = 8'hFF; req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rstw_outputs", {22'd0, st, rdata, 1'b0, ready, 1'b0, err}, 32'd0);
    rst = 1'b0; req = 1'b0;
    run_txn(1'b0, 8'h05, 8'h00, "rstw_rd", lat, rd, er);
    chk("rstw_rd_data", 32'(rd), 32'h11);

    // Reset in RESP discards the pending write.
    we = 1'b1; addr = 8'h05; wdata = 8'hEE; req = 1'b1;
    wait_ready(p1);
    chk("rstr_reached", 32'(p1 >= 0), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstr_outputs", {22'd0, st, rdata, 1'b0, ready, 1'b0, err}, 32'd0);
    rst = 1'b0; req = 1'b0;
    run_txn(1'b0, 8'h05, 8'h00, "rstr_rd", lat, rd, er);
    chk("rstr_rd_data", 32'(rd), 32'h11);

    // WAIT_CYCLES=0, DEPTH=16 instance.
    sel = 1'b1;
    tick();
    run_txn(1'b1, 8'h00, 8'h5A, "b_wr00", lat, rd, er);
    chk("b_wr00_lat", 32'(lat), 32'd1);
    run_txn(1'b0, 8'h00, 8'h00, "b_rd00", lat, rd, er);
    chk("b_rd00_lat", 32'(lat), 32'd1);
    chk("b_rd00_data", 32'(rd), 32'h5A);
    run_txn(1'b1, 8'h20, 8'h77, "b_wr20", lat, rd, er);
    chk("b_wr20_lat", 32'(lat), 32'd1);
    chk("b_wr20_err", 32'(er), 32'd1);
    chk("b_wr20_rdata_kept", 32'(rd), 32'h5A);
    run_txn(1'b0, 8'h20, 8'h00, "b_rd20", lat, rd, er);
    chk("b_rd20_data", 32'(rd), 32'h00);
    chk("b_rd20_err", 32'(er), 32'd1);
    run_txn(1'b0, 8'h00, 8'h00, "b_rd00b", lat, rd, er);
    chk("b_rd00b_data", 32'(rd), 32'h5A);
    chk("b_rd00b_err", 32'(er), 32'd0);
    run_txn(1'b1, 8'h0F, 8'hC3, "b_wr0f", lat, rd, er);
    chk("b_wr0f_err", 32'(er), 32'd0);
    run_txn(1'b0, 8'h0F, 8'h00, "b_rd0f", lat, rd, er);
    chk("b_rd0f_data", 32'(rd), 32'hC3);
    chk("b_rd0f_err", 32'(er), 32'd0);
    run_txn(1'b0, 8'h10, 8'h00, "b_rd10", lat, rd, er);
    chk("b_rd10_data", 32'(rd), 32'h00);
    chk("b_rd10_err", 32'(er), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/simple_mem_responder.md
# simple_mem_responder

Data-memory responder for the `simple_cpu` memory port. It sits on the target side of the `mem_req`/`mem_ready` handshake and serves each CPU load and store from an internal word array. It inserts a configurable number of wait states and flags out-of-range addresses. It is the memory model wired behind `tb_if` in place of a behavioural memory, and is also synthesizable as a small on-chip RAM.

## Interface
- `ADDR_W`, default 8: address width; must match the CPU `mem_addr`.
- `DATA_W`, default 8: data width; must match the CPU `mem_wdata`/`mem_rdata`.
- `DEPTH`, default 256: number of implemented words, 1..2**ADDR_W. Addresses ≥ DEPTH are out of range.
- `WAIT_CYCLES`, default 2: wait states inserted before the response, 0..15.

- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req` in 1: request from the CPU; held high until the CPU sees `mem_ready`.
- `mem_we` in 1: 1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr` in ADDR_W: word address.
- `mem_wdata` in DATA_W: write data.
- `mem_ready` out 1: response strobe, high for exactly one cycle per completed transaction.
- `mem_rdata` out DATA_W: read data, valid in the `mem_ready` cycle of a read.
- `mem_err` out 1: high together with `mem_ready` when the transaction address was out of range.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - If `mem_req`=1, capture `mem_we`, `mem_addr` and `mem_wdata` into registers at the clock edge.
  - Go to WAIT with `cnt`=WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RESP.
- **WAIT**
  - Captured values are used; bus changes during WAIT are ignored.
  - If `mem_req`=0, the transaction aborts: return to IDLE, no response, no write.
  - Else if `cnt`=0, go to RESP.
  - Else decrement `cnt`.
- **Entry to RESP** (on the clock edge)
  - For a read in range, `mem_rdata` is loaded from mem[addr].
  - For a read out of range, `mem_rdata` is loaded with 0.
  - For a write, `mem_rdata` is unchanged.
  - `mem_err` is set to (addr ≥ DEPTH).
- **RESP**
  - `mem_ready`=1 and `mem_err` is valid.
  - For an in-range write, mem[addr] is written at the edge that ends RESP. An out-of-range write is dropped.
  - Next state is always IDLE. The request seen in the RESP cycle is the current one and is not re-accepted.
- Outputs are registered and are not combinational from the inputs.
- Array contents are not reset; the array is uninitialised until written.
- Read-after-write to the same address in the following transaction returns the new data.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `mem_err`=0, `cnt`=0.
- Latency: if `mem_req` is first high in IDLE cycle n, `mem_ready` is high in cycle n+1+WAIT_CYCLES only.
- Throughput: a new request can be accepted in cycle n+2+WAIT_CYCLES (the IDLE cycle after RESP). Steady-state back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- CPU contract: `mem_req` is dropped, or a new request is presented, in the cycle after `mem_ready`. A `mem_req` held continuously is treated as a new transaction in that IDLE cycle.
- `mem_ready` is never high in two consecutive cycles.
- Reset mid-transaction, in WAIT or RESP: the next cycle is IDLE with all outputs at their reset values and any pending write discarded. Reset has priority over every other event.
- Address wrap: none. Addresses ≥ DEPTH never alias into the array.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `mem_req`=1 → `mem_ready`, `mem_rdata` and `mem_err` stay 0 throughout; the first request after release is accepted normally.
- **Write/read, WAIT_CYCLES=2:**
  - Write 0xA5 to 0x10 with request in cycle n → `mem_ready` high only in n+3, `mem_err`=0.
  - Read 0x10 with request in cycle m → `mem_ready` in m+3 with `mem_rdata`=0xA5.
- **Back-to-back, `mem_req` held high:** write 0x3C to 0x01, then read 0x01 → ready pulses are 4 cycles apart and the read returns 0x3C.
- **Zero wait, WAIT_CYCLES=0:** read request in cycle n → `mem_ready` in n+1; `mem_ready` low in n+2.
- **Out of range, DEPTH=16:**
  - Write 0x77 to 0x20 → `mem_ready`=1 and `mem_err`=1.
  - Read 0x20 → `mem_rdata`=0 and `mem_err`=1.
  - Read 0x00 afterwards → previously written value unchanged.
- **Abort and reset:**
  - Write 0xFF to 0x05, then drop `mem_req` in the first WAIT cycle → no `mem_ready`; a later read of 0x05 returns the old value.
  - Repeat with `rst` pulsed in WAIT instead → same result, all outputs 0.
